// File: rtl/pfd_pkg.sv
// Shared types and constants for the sampled-edge PFD / counter TDC.
// Holds the measurement FSM state encoding and signed saturation helpers.

package pfd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2
  } pfd_state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_TOL    = 1;
  localparam int DEF_LOCK_COUNT  = 16;
  localparam int DEF_DEADZONE    = 1;

  // Symmetric clip limits: the most negative code is never produced.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -sat_max(width);
  endfunction

endpackage

// File: rtl/pfd_edge_sync.sv
// Multi-flop synchroniser for one asynchronous input followed by a delay
// flop; emits a single-cycle pulse on each synchronised rising edge.

module pfd_edge_sync
  import pfd_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pfd_tdc.sv
// Sampled-edge phase-frequency detector with counter-based TDC, cycle-slip
// detection and lock tracking. Optional dead zone: define PFD_DEADZONE_EN.

module pfd_tdc
  import pfd_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_TOL    = DEF_LOCK_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT
`ifdef PFD_DEADZONE_EN
  ,
  parameter int DEADZONE    = DEF_DEADZONE
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic signed [CNT_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    cycle_slip,
  output logic                    saturated,
  output logic                    locked
);

  localparam int                      LCW       = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]        CNT_MAX   = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
  localparam logic signed [CNT_W-1:0] ERR_MAX   = CNT_W'(sat_max(CNT_W));
  localparam logic signed [CNT_W-1:0] ERR_MIN   = CNT_W'(sat_min(CNT_W));
  localparam logic [CNT_W-1:0]        TOL       = CNT_W'(LOCK_TOL);
  localparam logic [LCW-1:0]          LOCK_FULL = LCW'(LOCK_COUNT);
`ifdef PFD_DEADZONE_EN
  localparam logic [CNT_W-1:0]        DZ        = CNT_W'(DEADZONE);
`endif

  logic ref_rise;
  logic fb_rise;

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (ref_in),
    .rise_o  (ref_rise)
  );

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (fb_in),
    .rise_o  (fb_rise)
  );

  pfd_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    up_q, up_d;
  logic                    dn_q, dn_d;
  logic signed [CNT_W-1:0] err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    slip_q, slip_d;
  logic                    clip_q, clip_d;
  logic [LCW-1:0]          lock_cnt_q, lock_cnt_d;
  logic                    locked_q, locked_d;
  logic [CNT_W-1:0]        err_abs;

  // Converts a lead count into the reported signed error; a dead zone
  // collapses small offsets to zero before anything downstream sees them.
  function automatic logic signed [CNT_W-1:0] measured(input logic [CNT_W-1:0] mag,
                                                       input logic neg);
    logic signed [CNT_W-1:0] v;
    v = $signed(mag);
`ifdef PFD_DEADZONE_EN
    if (mag <= DZ) v = '0;
`endif
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    err_d   = err_q;
    valid_d = 1'b0;
    slip_d  = 1'b0;
    clip_d  = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_rise && fb_rise) begin
            err_d   = '0;
            valid_d = 1'b1;
          end else if (ref_rise) begin
            state_d = LEAD_REF;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
          end else if (fb_rise) begin
            state_d = LEAD_FB;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
          end
        end

        LEAD_REF: begin
          if (fb_rise) begin
            err_d   = measured(cnt_q, 1'b0);
            valid_d = 1'b1;
            clip_d  = sat_q;
            sat_d   = 1'b0;
            if (ref_rise) begin
              cnt_d = CNT_ONE;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (ref_rise) begin
            // A second reference edge before feedback arrived: report a full-scale slip
            err_d   = ERR_MAX;
            valid_d = 1'b1;
            slip_d  = 1'b1;
            clip_d  = 1'b1;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        LEAD_FB: begin
          if (ref_rise) begin
            err_d   = measured(cnt_q, 1'b1);
            valid_d = 1'b1;
            clip_d  = sat_q;
            sat_d   = 1'b0;
            if (fb_rise) begin
              cnt_d = CNT_ONE;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (fb_rise) begin
            err_d   = ERR_MIN;
            valid_d = 1'b1;
            slip_d  = 1'b1;
            clip_d  = 1'b1;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  // up/dn follow the next state so they are registered alongside it.
  always_comb begin
`ifdef PFD_DEADZONE_EN
    up_d = (state_d == LEAD_REF) && (cnt_d > DZ);
    dn_d = (state_d == LEAD_FB)  && (cnt_d > DZ);
`else
    up_d = (state_d == LEAD_REF);
    dn_d = (state_d == LEAD_FB);
`endif
  end

  always_comb begin
    err_abs    = err_d[CNT_W-1] ? $unsigned(-err_d) : $unsigned(err_d);
    lock_cnt_d = lock_cnt_q;
    locked_d   = (lock_cnt_q == LOCK_FULL);
    if (!en) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (valid_d) begin
      if (slip_d || (err_abs > TOL)) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q != LOCK_FULL) begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      err_q      <= '0;
      valid_q    <= 1'b0;
      slip_q     <= 1'b0;
      clip_q     <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      slip_q     <= slip_d;
      clip_q     <= clip_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign up         = up_q;
  assign dn         = dn_q;
  assign phase_err  = err_q;
  assign err_valid  = valid_q;
  assign cycle_slip = slip_q;
  assign saturated  = clip_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pfd_tdc.sv
// Scoreboard bench for pfd_tdc: directed edge pairs push expected strobes,
// a negedge monitor pops and compares every err_valid the DUT presents.

module tb_pfd_tdc;

  localparam int CNT_W = 8;

  typedef struct {
    int err;
    int slip;
    int sat;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    en;
  logic                    ref_in;
  logic                    fb_in;
  logic                    up;
  logic                    dn;
  logic signed [CNT_W-1:0] phase_err;
  logic                    err_valid;
  logic                    cycle_slip;
  logic                    saturated;
  logic                    locked;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  int   upCycles = 0;
  int   dnCycles = 0;
  bit   bothHigh = 1'b0;

  pfd_tdc #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .LOCK_TOL    (1),
    .LOCK_COUNT  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .ref_in     (ref_in),
    .fb_in      (fb_in),
    .up         (up),
    .dn         (dn),
    .phase_err  (phase_err),
    .err_valid  (err_valid),
    .cycle_slip (cycle_slip),
    .saturated  (saturated),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: counts up/dn activity and checks every strobe against the queue
  always @(negedge clk) begin
    if (up) upCycles++;
    if (dn) dnCycles++;
    if (up && dn) bothHigh = 1'b1;
    if (err_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("phase_err", int'(phase_err), monExp.err);
        checkOutput("cycle_slip", int'(cycle_slip), monExp.slip);
        checkOutput("saturated", int'(saturated), monExp.sat);
      end
    end else if (cycle_slip || saturated) begin
      checkOutput("stray_flag", 1, 0);
    end
  end

  // One edge pair: the leading input rises, the other follows gap cycles later
  task automatic applyStimulus(input bit refFirst, input int gap, input int expErr,
                               input int expUp, input int expDn);
    expQ.push_back(exp_t'{expErr, 0, 0});
    upCycles = 0;
    dnCycles = 0;
    @(negedge clk);
    if (gap == 0) begin
      ref_in = 1'b1;
      fb_in  = 1'b1;
    end else if (refFirst) begin
      ref_in = 1'b1;
    end else begin
      fb_in = 1'b1;
    end
    repeat (gap) @(negedge clk);
    ref_in = 1'b1;
    fb_in  = 1'b1;
    repeat (2) @(negedge clk);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("up_cycles", upCycles, expUp);
    checkOutput("dn_cycles", dnCycles, expDn);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit lockRef[4];
    int lockGap[4];
    int lockErr[4];
    int lockUp[4];
    int lockDn[4];
    int lockExp[4];
    int waitCnt;

    lockRef = '{1'b1, 1'b1, 1'b0, 1'b1};
    lockGap = '{1, 0, 1, 1};
    lockErr = '{1, 0, -1, 1};
    lockUp  = '{1, 0, 0, 1};
    lockDn  = '{0, 0, 1, 0};
    lockExp = '{0, 0, 0, 1};

    reset_n = 1'b0;
    en      = 1'b1;
    ref_in  = 1'b0;
    fb_in   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_up", int'(up), 0);
    checkOutput("rst_dn", int'(dn), 0);
    checkOutput("rst_phase_err", int'(phase_err), 0);
    checkOutput("rst_err_valid", int'(err_valid), 0);
    checkOutput("rst_locked", int'(locked), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus(1'b1, 5, 5, 5, 0);
    applyStimulus(1'b0, 3, -3, 0, 3);
    applyStimulus(1'b1, 0, 0, 0, 0);

    // Cycle slip: a second reference edge 200 cycles later, then fb closes 3 later
    expQ.push_back(exp_t'{127, 1, 1});
    expQ.push_back(exp_t'{3, 0, 0});
    @(negedge clk);
    ref_in = 1'b1;
    repeat (2) @(negedge clk);
    ref_in = 1'b0;
    repeat (198) @(negedge clk);
    ref_in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("slip_up_held", int'(up), 1);
    checkOutput("slip_locked", int'(locked), 0);
    fb_in = 1'b1;
    repeat (2) @(negedge clk);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(lockRef[i], lockGap[i], lockErr[i], lockUp[i], lockDn[i]);
      checkOutput("locked_seq", int'(locked), lockExp[i]);
    end
    applyStimulus(1'b1, 5, 5, 5, 0);
    checkOutput("locked_after_miss", int'(locked), 0);

    // Reset mid-measurement with the lead counter at 10
    @(negedge clk);
    ref_in = 1'b1;
    repeat (2) @(negedge clk);
    ref_in = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("pre_rst_up", int'(up), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_up", int'(up), 0);
    checkOutput("midrst_phase_err", int'(phase_err), 0);
    checkOutput("midrst_err_valid", int'(err_valid), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 4, 4, 4, 0);

    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("up_dn_exclusive", int'(bothHigh), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
